fetch_queue: RTL

Parametrised instruction-fetch stage with a prefetch queue, replacing the single-register fetch/IF-ID pair of the 5-stage MIPS datapath. It drives the synchronous instruction ROM, buffers up to DEPTH fetched words tagged with their next-PC, and presents them to the decode stage. It handles decode stalls, branch redirects with in-flight discard, an end-of-program halt, and debug-unit freeze/restart.

---
 rtl/fetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage with a prefetch queue: drives the synchronous ROM, buffers
// fetched words tagged with their next-PC, and handles stall, redirect, halt and debug control.
module fetch_queue #(
   parameter int                  PC_WIDTH    = 8,
   parameter int                  INSTR_WIDTH = 32,
   parameter int                  DEPTH       = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     debugEnable,
   input  logic                     debugReset,
   output logic [PC_WIDTH-1:0]      imemAddr,
   output logic                     imemReq,
   input  logic [INSTR_WIDTH-1:0]   imemData,
   input  logic                     redirect,
   input  logic [PC_WIDTH-1:0]      redirectPc,
   input  logic                     halt,
   input  logic                     stall,
   output logic [INSTR_WIDTH-1:0]   instrOut,
   output logic [PC_WIDTH-1:0]      pcNextOut,
   output logic                     instrValid,
   output logic [$clog2(DEPTH):0]   queueCount,
   output logic                     halted
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {RUN, HALT} state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  fetchPc_q, fetchPc_d;
   logic                 inflight_q, inflight_d;
   logic [PC_WIDTH-1:0]  inflightPc_q, inflightPc_d;
   logic                 drop_q, drop_d;
   logic [PW-1:0]        wrPtr_q, wrPtr_d;
   logic [PW-1:0]        rdPtr_q, rdPtr_d;
   logic [CW-1:0]        count_q, count_d;

   logic [INSTR_WIDTH-1:0] instrMem [DEPTH];
   logic [PC_WIDTH-1:0]    pcMem    [DEPTH];

   logic flush;
   logic issue;
   logic push;
   logic pop;

   // Issue credit counts the outstanding fetch but not a same-cycle pop, so the queue cannot overflow.
   always_comb begin
      flush = debugEnable && (debugReset || redirect);
      issue = reset && debugEnable && !debugReset && !redirect && (state_q == RUN)
              && ((count_q + CW'(inflight_q)) < DEPTH_C);
      push  = inflight_q && !drop_q && !flush;
      pop   = (count_q != '0) && !stall && debugEnable && !flush;

      fetchPc_d    = fetchPc_q;
      inflight_d   = issue;
      inflightPc_d = issue ? fetchPc_q : inflightPc_q;
      drop_d       = flush && inflight_q;
      wrPtr_d      = push ? wrPtr_q + PW'(1) : wrPtr_q;
      rdPtr_d      = pop ? rdPtr_q + PW'(1) : rdPtr_q;
      count_d      = count_q + CW'(push) - CW'(pop);
      state_d      = state_q;

      if (debugEnable && debugReset) begin
         fetchPc_d = RESET_PC;
         state_d   = RUN;
      end else if (debugEnable && redirect) begin
         fetchPc_d = redirectPc;
      end else begin
         if (issue) begin
            fetchPc_d = fetchPc_q + PC_WIDTH'(1);
         end
         if (debugEnable && halt) begin
            state_d = HALT;
         end
      end

      // A flush discards the queue contents, the head being popped and any response arriving now.
      if (flush) begin
         rdPtr_d = wrPtr_q;
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= RUN;
         fetchPc_q    <= RESET_PC;
         inflight_q   <= 1'b0;
         inflightPc_q <= '0;
         drop_q       <= 1'b0;
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         fetchPc_q    <= fetchPc_d;
         inflight_q   <= inflight_d;
         inflightPc_q <= inflightPc_d;
         drop_q       <= drop_d;
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: the head is only exposed while count is non-zero.
   always_ff @(posedge clock) begin
      if (push) begin
         instrMem[wrPtr_q] <= imemData;
         pcMem[wrPtr_q]    <= inflightPc_q + PC_WIDTH'(1);
      end
   end

   always_comb begin
      instrValid = (count_q != '0);
      instrOut   = instrValid ? instrMem[rdPtr_q] : '0;
      pcNextOut  = instrValid ? pcMem[rdPtr_q] : '0;
      queueCount = count_q;
      halted     = (state_q == HALT);
      imemReq    = issue;
      imemAddr   = fetchPc_q;
   end

endmodule
